// File: rtl/merge_write_arbiter.sv
// Write-port front end for the shared channel-merge FIFO: runs the FIFO reset/init
// sequence, round-robin arbitrates TDC channels, tags words with channel ID, counts WRERR.
module merge_write_arbiter #(
  parameter int unsigned N_CH        = 4,
  parameter int unsigned CH_W        = 2,
  parameter int unsigned PAYLOAD_W   = 30,
  parameter int unsigned RST_CYCLES  = 5,
  parameter int unsigned WAIT_CYCLES = 8
) (
  input  logic                        Wclk,
  input  logic                        rst,
  input  logic                        clear,
  input  logic [N_CH-1:0]             ch_valid,
  input  logic [N_CH*PAYLOAD_W-1:0]   ch_data,
  output logic [N_CH-1:0]             ch_ready,
  input  logic                        fifo_almost_full,
  input  logic                        fifo_full,
  input  logic                        fifo_wrerr,
  output logic                        fifo_rst,
  output logic                        fifo_wren,
  output logic [31:0]                 fifo_din,
  output logic                        running,
  output logic [CH_W-1:0]             last_grant,
  output logic [15:0]                 wrerr_count
);

  localparam int unsigned CNT_MAX = (RST_CYCLES > WAIT_CYCLES) ? RST_CYCLES : WAIT_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned DIN_W   = 32;
  localparam int unsigned ERR_W   = 16;

  typedef enum logic [1:0] {S_RST, S_WAIT, S_RUN} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               fifo_rst_q, fifo_rst_d;
  logic               wren_q, wren_d;
  logic [DIN_W-1:0]   din_q, din_d;
  logic               running_q, running_d;
  logic [CH_W-1:0]    last_q, last_d;
  logic [ERR_W-1:0]   err_q, err_d;

  logic               arb_en;
  logic               grant_vld;
  logic [CH_W-1:0]    grant_id;
  logic [CH_W-1:0]    scan_idx;
  logic [PAYLOAD_W-1:0] payload [N_CH];

  for (genvar g = 0; g < N_CH; g++) begin : g_unpack
    assign payload[g] = ch_data[g*PAYLOAD_W +: PAYLOAD_W];
  end

  // Round-robin scan starting one past the last granted channel
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
    scan_idx  = '0;
    arb_en    = (state_q == S_RUN) && !fifo_almost_full && !fifo_full;
    for (int unsigned k = 1; k <= N_CH; k++) begin
      scan_idx = last_q + CH_W'(k);
      if (arb_en && !grant_vld && ch_valid[scan_idx]) begin
        grant_vld = 1'b1;
        grant_id  = scan_idx;
      end
    end
    ch_ready = grant_vld ? (N_CH'(1) << grant_id) : '0;
  end

  // Sequencer, write register and error counter next-state
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    fifo_rst_d = fifo_rst_q;
    wren_d     = 1'b0;
    din_d      = din_q;
    running_d  = running_q;
    last_d     = last_q;
    err_d      = err_q;

    if (fifo_wrerr && (err_q != '1)) err_d = err_q + ERR_W'(1);

    if (clear) begin
      // Any word granted this cycle is dropped
      state_d    = S_RST;
      cnt_d      = '0;
      fifo_rst_d = 1'b1;
      running_d  = 1'b0;
      last_d     = CH_W'(N_CH - 1);
      err_d      = '0;
    end else begin
      case (state_q)
        S_RST: begin
          fifo_rst_d = 1'b1;
          if (cnt_q == CNT_W'(RST_CYCLES - 1)) begin
            state_d    = S_WAIT;
            cnt_d      = '0;
            fifo_rst_d = 1'b0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_WAIT: begin
          if (cnt_q == CNT_W'(WAIT_CYCLES - 1)) begin
            state_d   = S_RUN;
            cnt_d     = '0;
            running_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_RUN: begin
          if (grant_vld) begin
            wren_d = 1'b1;
            din_d  = {grant_id, payload[grant_id]};
            last_d = grant_id;
          end
        end
        default: begin
          state_d    = S_RST;
          cnt_d      = '0;
          fifo_rst_d = 1'b1;
          running_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge Wclk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_RST;
      cnt_q      <= '0;
      fifo_rst_q <= 1'b1;
      wren_q     <= 1'b0;
      din_q      <= '0;
      running_q  <= 1'b0;
      last_q     <= CH_W'(N_CH - 1);
      err_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      fifo_rst_q <= fifo_rst_d;
      wren_q     <= wren_d;
      din_q      <= din_d;
      running_q  <= running_d;
      last_q     <= last_d;
      err_q      <= err_d;
    end
  end

  assign fifo_rst    = fifo_rst_q;
  assign fifo_wren   = wren_q;
  assign fifo_din    = din_q;
  assign running     = running_q;
  assign last_grant  = last_q;
  assign wrerr_count = err_q;

endmodule

// File: doc/merge_write_arbiter.md
Name: merge_write_arbiter

Overview:
- Sits in the merging stage, in front of the write port of the shared FIFO36E1-based channel-merge memory.
- Runs the FIFO reset/initialisation sequence and arbitrates round-robin among N_CH TDC channel requesters.
- Tags each granted word with its channel ID and drives WREN/DI; stalls requesters on FIFO almost-full or full.
- Counts write errors reported by the FIFO.

Parameters:
- N_CH, 4, number of requesting channels; must be a power of 2, range 2..8.
- CH_W, 2, channel-ID width; must equal log2(N_CH).
- PAYLOAD_W, 30, per-channel payload width; must equal 32-CH_W.
- RST_CYCLES, 5, cycles fifo_rst is held high (FIFO36E1 minimum is 5).
- WAIT_CYCLES, 8, cycles after fifo_rst falls before writes are allowed.

Ports:
- Wclk  in  1  write-domain clock (FIFO WRCLK).
- rst  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous soft clear; re-runs the FIFO reset sequence.
- ch_valid  in  N_CH  per-channel word valid.
- ch_data  in  N_CH*PAYLOAD_W  per-channel payloads; channel i occupies bits [i*PAYLOAD_W +: PAYLOAD_W].
- ch_ready  out  N_CH  one-hot grant; a transfer occurs when ch_valid[i] & ch_ready[i].
- fifo_almost_full  in  1  from FIFO ALMOSTFULL.
- fifo_full  in  1  from FIFO FULL.
- fifo_wrerr  in  1  from FIFO WRERR.
- fifo_rst  out  1  to FIFO RST, active-high.
- fifo_wren  out  1  to FIFO WREN, registered.
- fifo_din  out  32  to FIFO DI, registered, {ch_id, payload}.
- running  out  1  high in S_RUN.
- last_grant  out  CH_W  ID of the most recently granted channel.
- wrerr_count  out  16  saturating count of fifo_wrerr pulses.

Behaviour:
- Reset (rst low, asynchronous):
  - state=S_RST, counter=0, fifo_rst=1.
  - fifo_wren=0, fifo_din=0, ch_ready=0, running=0.
  - last_grant=N_CH-1, so channel 0 has first priority; wrerr_count=0.
- S_RST: fifo_rst=1; counter runs 0..RST_CYCLES-1; then state -> S_WAIT, counter=0, fifo_rst=0.
- S_WAIT: fifo_rst=0, fifo_wren=0; counter runs 0..WAIT_CYCLES-1; then state -> S_RUN.
- S_RUN: running=1. The arbiter is enabled when fifo_almost_full=0 and fifo_full=0.
- Grant (combinational):
  - Scan channels starting at last_grant+1 (mod N_CH). The first channel with ch_valid=1 gets ch_ready=1; all other ch_ready bits are 0.
  - When the arbiter is disabled or no channel is valid, ch_ready=0.
- Write (next rising edge after a transfer):
  - fifo_wren=1, fifo_din={granted ID, granted payload}, last_grant=granted ID.
  - Any cycle without a transfer: fifo_wren=0, fifo_din holds its previous value.
- Latency: exactly 1 cycle from transfer to fifo_wren. Throughput: one word per cycle.
- A channel holding ch_valid high is granted at least once every N_CH cycles while the arbiter is enabled.
- Almost-full gating stops grants immediately. At most one in-flight word is written after fifo_almost_full rises; that word is within the offset margin.
- If fifo_full=1 with a write in flight, the write is still issued; the resulting fifo_wrerr is counted.
- wrerr_count: +1 on each cycle fifo_wrerr=1, saturating at 16'hFFFF. It is cleared by rst and by clear.
- clear=1 in any state:
  - Next cycle: state=S_RST, counter=0, fifo_rst=1, fifo_wren=0, ch_ready=0.
  - last_grant resets to N_CH-1.
  - A word granted in the same cycle as clear is discarded and not written.
- clear held high keeps the block in S_RST with the counter at 0; the sequence resumes when clear falls.
- fifo_wren is guaranteed 0 in S_RST and S_WAIT and for the first cycle of S_RUN.
- Requesters must keep ch_data stable while ch_valid=1 and ch_ready=0.

Test Plan:
- Reset/init:
  - Stimulus: release rst, defaults.
  - Required: fifo_rst high for exactly 5 cycles, then low; running rises 8 cycles later; fifo_wren=0 throughout.
- Round-robin:
  - Stimulus: all 4 ch_valid high continuously; ch_data[i]=payload i+1.
  - Required: fifo_din sequence is 32'h00000001, 32'h40000002, 32'h80000003, 32'hC0000004, repeating; one write per cycle.
- Sparse fairness:
  - Stimulus: only ch1 and ch3 valid.
  - Required: grants alternate 1,3,1,3; last_grant tracks each grant.
- Backpressure:
  - Stimulus: raise fifo_almost_full mid-stream.
  - Required: ch_ready=0 the same cycle; at most 1 further fifo_wren pulse; resumes at the next channel in order when the flag drops.
- Error count:
  - Stimulus: pulse fifo_wrerr 3 times.
  - Required: wrerr_count=3.
  - Stimulus: force 70000 pulses.
  - Required: wrerr_count stays at 16'hFFFF.
- Soft clear mid-run:
  - Stimulus: clear for 1 cycle during streaming.
  - Required: no fifo_wren the next cycle; fifo_rst high for 5 cycles; wrerr_count=0; the first grant after restart goes to ch0.
